// File: rtl/utopia_rx_mux_if.sv
// Purpose: UTOPIA Level-1 Rx PHY pins plus the outbound cell byte stream of utopia_rx_mux.
// Latency: none, wiring only.
// Backpressure: out_ready stalls the stream; the PHY side is paced by per-port active-low rx_en.
interface utopia_rx_mux_if #(
  parameter int NUM_RX = 16,
  parameter int DATA_W = 8
);
  localparam int PW = $clog2(NUM_RX);

  // PHY side: port p data lives at rx_data[p*DATA_W +: DATA_W]
  logic [NUM_RX-1:0]        rx_clav;
  logic [NUM_RX-1:0]        rx_soc;
  logic [NUM_RX*DATA_W-1:0] rx_data;
  logic [NUM_RX-1:0]        rx_en;

  // Cell byte stream towards lookup/forward
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_sop;
  logic                     out_eop;
  logic [PW-1:0]            out_port;

  // The mux: reads PHYs and drives the stream
  modport master (
    input  rx_clav, rx_soc, rx_data, out_ready,
    output rx_en, out_valid, out_data, out_sop, out_eop, out_port
  );

  // PHYs plus the downstream consumer
  modport slave (
    output rx_clav, rx_soc, rx_data, out_ready,
    input  rx_en, out_valid, out_data, out_sop, out_eop, out_port
  );
endinterface

// File: rtl/utopia_rx_mux.sv
// Purpose: round-robin poll of NUM_RX UTOPIA L1 Rx PHYs, one cell buffered, store-and-forward byte stream.
// Latency: first output byte valid 2 cycles after the last rx_en-low cycle of a cell.
// Backpressure: out_ready low holds the current byte stable; no new cell is polled until the buffer drains.
module utopia_rx_mux #(
  parameter int NUM_RX     = 16,
  parameter int CELL_BYTES = 53,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_RX-1:0]  port_en,
  utopia_rx_mux_if.master    bus,
  output logic [CNT_W-1:0]   cell_cnt,
  output logic [7:0]         drop_cnt,
  output logic               err_pulse
);
  localparam int PW = $clog2(NUM_RX);
  localparam int CW = $clog2(CELL_BYTES + 1);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_RX - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(CELL_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RECV, SEND} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     port_q, port_d;
  // RECV: cycles since the grant (byte cnt-1 is sampled); SEND: index of the byte on out_data
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_RX-1:0] rx_en_q, rx_en_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cell_cnt_q, cell_cnt_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] cell_buf_q [CELL_BYTES];
  logic [DATA_W-1:0] cell_buf_d [CELL_BYTES];

  logic [NUM_RX-1:0] cand;
  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  int                arb_p;
  logic [PW-1:0]     arb_idx;
  logic [CW-1:0]     byte_idx;
  logic              smp_soc;
  logic [DATA_W-1:0] smp_dat;

  assign cand    = bus.rx_clav & port_en;
  assign smp_soc = bus.rx_soc[port_q];
  assign smp_dat = bus.rx_data[int'(port_q)*DATA_W +: DATA_W];

  // Round-robin arbiter: first candidate at or after rr_ptr, wrapping at NUM_RX
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_p     = 0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_RX; i++) begin
      arb_p = int'(rr_ptr_q) + i;
      if (arb_p >= NUM_RX) arb_p = arb_p - NUM_RX;
      arb_idx = PW'(arb_p);
      if (!grant_vld && cand[arb_idx]) begin
        grant_vld = 1'b1;
        grant_idx = arb_idx;
      end
    end
  end

  // Next-state logic for the poll / receive / send sequence
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    port_d      = port_q;
    cnt_d       = cnt_q;
    rx_en_d     = rx_en_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    cell_cnt_d  = cell_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    cell_buf_d  = cell_buf_q;
    byte_idx    = cnt_q - CW'(1);
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d  = RECV;
          port_d   = grant_idx;
          rr_ptr_d = (grant_idx == LAST_PORT) ? '0 : grant_idx + PW'(1);
          cnt_d    = '0;
          rx_en_d  = '1;
          rx_en_d[grant_idx] = 1'b0;
        end
      end
      RECV: begin
        cnt_d = cnt_q + CW'(1);
        // Enable has been low for CELL_BYTES cycles after this one
        if (cnt_q == LAST_BYTE) rx_en_d = '1;
        // Data lags rx_en by one cycle, so nothing to sample in the first RECV cycle
        if (cnt_q != '0) begin
          if (smp_soc != (byte_idx == '0)) begin
            rx_en_d = '1;
            err_d   = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cell_buf_d[byte_idx] = smp_dat;
            if (byte_idx == LAST_BYTE) begin
              state_d     = SEND;
              cnt_d       = '0;
              out_valid_d = 1'b1;
            end
          end
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (cnt_q == LAST_BYTE) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = IDLE;
            if (cell_cnt_q != '1) cell_cnt_d = cell_cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any partial cell without counting it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      port_q      <= '0;
      cnt_q       <= '0;
      rx_en_q     <= '1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cell_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < CELL_BYTES; i++) cell_buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      port_q      <= port_d;
      cnt_q       <= cnt_d;
      rx_en_q     <= rx_en_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      cell_cnt_q  <= cell_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      cell_buf_q  <= cell_buf_d;
    end
  end

  assign bus.rx_en     = rx_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? cell_buf_q[cnt_q] : '0;
  assign bus.out_sop   = out_valid_q && (cnt_q == '0);
  assign bus.out_eop   = out_valid_q && (cnt_q == LAST_BYTE);
  assign bus.out_port  = port_q;
  assign cell_cnt      = cell_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign err_pulse     = err_q;
endmodule

// File: tb/tb_utopia_rx_mux.sv
// Purpose: directed bench for utopia_rx_mux with a behavioural PHY per port and a stream monitor.
// Latency: checks the 2-cycle en-to-valid latency on every cell.
// Backpressure: drives out_ready steady or toggling and checks output stability while stalled.
module tb_utopia_rx_mux;
  localparam int NUM_RX     = 16;
  localparam int CELL_BYTES = 53;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_RX-1:0] port_en;
  logic [15:0]       cell_cnt;
  logic [7:0]        drop_cnt;
  logic              err_pulse;

  utopia_rx_mux_if #(.NUM_RX(NUM_RX), .DATA_W(8)) bus_if ();

  utopia_rx_mux #(.NUM_RX(NUM_RX), .CELL_BYTES(CELL_BYTES), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .port_en(port_en), .bus(bus_if),
    .cell_cnt(cell_cnt), .drop_cnt(drop_cnt), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t = 0;
  logic [NUM_RX-1:0] en_prev;
  int ptr [NUM_RX];
  logic [7:0] seed [NUM_RX];
  int run [NUM_RX];
  int last_run [NUM_RX];
  int bad_port, bad_k;
  int grant_q[$];
  int exp_ports[$];
  int cur_port;
  int mon_idx, rx_cells, hs_cnt, overlap, err_cycles, valid_cycles, stab_err, last_low_t;
  bit toggle;
  logic valid_prev, hold_prev, sop_prev, eop_prev;
  logic [7:0] d_prev;
  logic [3:0] port_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: PHY responds to last cycle's rx_en, then rx_en and the stream are monitored
  task automatic cycle();
    int low;
    logic [7:0] expd;
    @(negedge clk);
    t++;
    for (int p = 0; p < NUM_RX; p++) begin
      if (!en_prev[p]) begin
        bus_if.rx_data[p*8 +: 8] = seed[p] + 8'(ptr[p]);
        bus_if.rx_soc[p] = (ptr[p] == 0) || (p == bad_port && ptr[p] == bad_k);
        ptr[p]++;
      end else begin
        bus_if.rx_soc[p] = 1'b0;
      end
      if (bus_if.rx_en[p] && !en_prev[p]) ptr[p] = 0;
    end
    low = 0;
    for (int p = 0; p < NUM_RX; p++) begin
      if (!bus_if.rx_en[p]) begin
        low++;
        last_low_t = t;
        if (en_prev[p]) begin
          grant_q.push_back(p);
          run[p] = 0;
        end
        run[p]++;
      end else if (!en_prev[p]) begin
        last_run[p] = run[p];
      end
    end
    if (low > 1) overlap++;
    en_prev = bus_if.rx_en;
    if (err_pulse) err_cycles++;
    if (toggle) bus_if.out_ready = !bus_if.out_ready;
    if (bus_if.out_valid) valid_cycles++;
    if (hold_prev && bus_if.out_valid &&
        (bus_if.out_data !== d_prev || bus_if.out_sop !== sop_prev ||
         bus_if.out_eop !== eop_prev || bus_if.out_port !== port_prev)) stab_err++;
    if (bus_if.out_valid && !valid_prev) chk("latency", t - last_low_t, 2);
    if (bus_if.out_valid && bus_if.out_ready) begin
      if (mon_idx == 0) begin
        cur_port = (exp_ports.size() > 0) ? exp_ports.pop_front() : -1;
        chk("out_port", bus_if.out_port, cur_port);
      end
      expd = seed[cur_port[3:0]] + 8'(mon_idx);
      chk("out_data", bus_if.out_data, expd);
      chk("out_sop", bus_if.out_sop, mon_idx == 0);
      chk("out_eop", bus_if.out_eop, mon_idx == CELL_BYTES - 1);
      hs_cnt++;
      if (mon_idx == CELL_BYTES - 1) begin
        rx_cells++;
        mon_idx = 0;
      end else begin
        mon_idx++;
      end
    end
    hold_prev  = bus_if.out_valid && !bus_if.out_ready;
    valid_prev = bus_if.out_valid;
    d_prev     = bus_if.out_data;
    sop_prev   = bus_if.out_sop;
    eop_prev   = bus_if.out_eop;
    port_prev  = bus_if.out_port;
  endtask

  // Assert reset (asynchronously), check reset values, clear bench state, release
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rx_en", bus_if.rx_en, 32'h0000FFFF);
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_out_sop", bus_if.out_sop, 0);
    chk("rst_out_eop", bus_if.out_eop, 0);
    chk("rst_out_data", bus_if.out_data, 0);
    chk("rst_out_port", bus_if.out_port, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_cell_cnt", cell_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    en_prev = '1;
    for (int p = 0; p < NUM_RX; p++) begin
      ptr[p] = 0; run[p] = 0; last_run[p] = 0;
    end
    bus_if.rx_soc = '0;
    bus_if.rx_clav = '0;
    bus_if.out_ready = 1'b1;
    toggle = 1'b0;
    bad_port = -1; bad_k = -1;
    grant_q.delete(); exp_ports.delete();
    mon_idx = 0; rx_cells = 0; hs_cnt = 0; overlap = 0; err_cycles = 0;
    valid_cycles = 0; stab_err = 0; valid_prev = 1'b0; hold_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int budget);
    int n;
    int s;
    n = 0;
    s = grant_q.size();
    while (grant_q.size() == s && n < budget) begin cycle(); n++; end
    chk("grant_seen", grant_q.size(), s + 1);
  endtask

  task automatic run_cells(input int target, input int budget);
    int n;
    n = 0;
    while (rx_cells < target && n < budget) begin cycle(); n++; end
    chk("cells_done", rx_cells, target);
    cycle();
    cycle();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    port_en = '1;
    bus_if.rx_clav = '0;
    bus_if.rx_soc = '0;
    bus_if.rx_data = '0;
    bus_if.out_ready = 1'b1;
    for (int p = 0; p < NUM_RX; p++) seed[p] = 8'h00;
    @(negedge clk);
    do_reset();

    // 1: one clean cell from port 3, bytes 0x00..0x34
    seed[3] = 8'h00;
    exp_ports.push_back(3);
    bus_if.rx_clav[3] = 1'b1;
    wait_grant(20);
    bus_if.rx_clav[3] = 1'b0;
    run_cells(1, 200);
    chk("t1_en_low_len", last_run[3], 53);
    chk("t1_grant", grant_q[0], 3);
    chk("t1_cell_cnt", cell_cnt, 1);
    chk("t1_handshakes", hs_cnt, 53);

    // 2: ports 0, 5, 15 hold clav; round-robin from rr_ptr 0
    do_reset();
    seed[0] = 8'h10; seed[5] = 8'h50; seed[15] = 8'hA0;
    exp_ports = '{0, 5, 15, 0, 5, 15};
    bus_if.rx_clav[0] = 1'b1; bus_if.rx_clav[5] = 1'b1; bus_if.rx_clav[15] = 1'b1;
    n = 0;
    while (grant_q.size() < 6 && n < 1000) begin cycle(); n++; end
    bus_if.rx_clav = '0;
    run_cells(6, 300);
    chk("t2_grants", grant_q.size(), 6);
    chk("t2_g0", grant_q[0], 0);
    chk("t2_g1", grant_q[1], 5);
    chk("t2_g2", grant_q[2], 15);
    chk("t2_g3", grant_q[3], 0);
    chk("t2_g4", grant_q[4], 5);
    chk("t2_g5", grant_q[5], 15);
    chk("t2_overlap", overlap, 0);
    chk("t2_cell_cnt", cell_cnt, 6);

    // 3: port 2 asserts soc again on byte 10
    seed[2] = 8'h20;
    bad_port = 2; bad_k = 10;
    valid_cycles = 0;
    bus_if.rx_clav[2] = 1'b1;
    n = 0;
    while (err_cycles == 0 && n < 100) begin cycle(); n++; end
    bus_if.rx_clav[2] = 1'b0;
    bad_port = -1;
    repeat (80) cycle();
    chk("t3_err_cycles", err_cycles, 1);
    chk("t3_drop_cnt", drop_cnt, 1);
    chk("t3_cell_cnt", cell_cnt, 6);
    chk("t3_no_valid", valid_cycles, 0);
    chk("t3_en_low_len", last_run[2], 12);
    chk("t3_rx_en_idle", bus_if.rx_en, 32'h0000FFFF);

    // 4: out_ready toggles every cycle while sending
    do_reset();
    seed[7] = 8'h33;
    exp_ports.push_back(7);
    bus_if.rx_clav[7] = 1'b1;
    wait_grant(20);
    bus_if.rx_clav[7] = 1'b0;
    toggle = 1'b1;
    run_cells(1, 400);
    toggle = 1'b0;
    bus_if.out_ready = 1'b1;
    chk("t4_stable", stab_err, 0);
    chk("t4_handshakes", hs_cnt, 53);
    chk("t4_cell_cnt", cell_cnt, 1);

    // 5: masked port is never granted; unmasking then masking mid-cell completes the cell
    grant_q.delete();
    seed[3] = 8'h80;
    port_en = 16'hFFF7;
    bus_if.rx_clav[3] = 1'b1;
    repeat (30) cycle();
    chk("t5_no_grant", grant_q.size(), 0);
    chk("t5_rx_en_idle", bus_if.rx_en, 32'h0000FFFF);
    exp_ports.push_back(3);
    port_en = '1;
    wait_grant(20);
    port_en[3] = 1'b0;
    bus_if.rx_clav[3] = 1'b0;
    run_cells(2, 200);
    port_en = '1;
    chk("t5_grant", grant_q[0], 3);
    chk("t5_en_low_len", last_run[3], 53);
    chk("t5_cell_cnt", cell_cnt, 2);
    chk("t5_drop_cnt", drop_cnt, 0);

    // 6: reset in the middle of sending, then a normal cell
    seed[1] = 8'h61;
    exp_ports.push_back(1);
    bus_if.rx_clav[1] = 1'b1;
    wait_grant(20);
    bus_if.rx_clav[1] = 1'b0;
    n = 0;
    while (mon_idx < 20 && n < 200) begin cycle(); n++; end
    chk("t6_reached_byte20", mon_idx, 20);
    chk("t6_valid_before_rst", bus_if.out_valid, 1);
    do_reset();
    seed[1] = 8'h71;
    exp_ports.push_back(1);
    bus_if.rx_clav[1] = 1'b1;
    wait_grant(20);
    bus_if.rx_clav[1] = 1'b0;
    run_cells(1, 200);
    chk("t6_cell_cnt", cell_cnt, 1);
    chk("t6_drop_cnt", drop_cnt, 0);
    chk("t6_handshakes", hs_cnt, 53);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
